bcd_converter_seq: RTL and testbench
====================================

Name: bcd_converter_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the iterative shift-add-3 (double dabble) algorithm.
- Processes one binary bit per clock, using an array of per-digit add-3 correction cells.
- Replaces the fully unrolled combinational converter in the display path.
- Feeds the seven-segment digit multiplexer on the Basys3 board from the LFSR/counter value.
- Uses a start/busy/done handshake so the producer can issue a new value at any idle time.

Parameters:
- BIN_W, 16, width of the unsigned binary input (range 4..32).
- DIGITS, 5, number of BCD output digits (range 1..10). A value smaller than ceil(BIN_W*log10(2)) makes overflow possible.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only while idle.
- bin_in  input  BIN_W  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out and overflow are updated.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 in bits [3:0]. Held between conversions.
- overflow  output  1  high when the last result did not fit in DIGITS digits. Held with bcd_out.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: busy=0, done=0, bcd_out=0, overflow=0, FSM in IDLE, internal registers cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE: if start=1 on a rising edge, capture bin_in into the binary shift register, clear the BCD scratch register and the sticky overflow flag, load the bit counter with BIN_W, set busy=1, go to SHIFT.
  - start=0 stays in IDLE.
  - done is 0 in IDLE except for its pulse cycle.
- SHIFT, one edge per bit:
  - Correct every scratch digit: a digit >= 5 gets +3, truncated to 4 bits; a digit <= 4 is unchanged.
  - Shift {scratch, binary} left by one bit.
  - If the bit shifted out of the top digit is 1, set sticky overflow.
  - Decrement the counter. On the edge where the counter reaches 0, go to FINISH.
- FINISH, one edge: update bcd_out and overflow, assert done=1 for exactly one cycle, set busy=0, return to IDLE.
  - If overflow is set, bcd_out saturates to all digits = 9.
  - Otherwise bcd_out = the scratch register.
- Latency: with start accepted on edge 0, done is high in the cycle after edge BIN_W+1. The total is BIN_W+1 clocks; busy is high for BIN_W+1 cycles.
- Back-to-back: start may be high in the done cycle. The FSM is already in IDLE, so that start is accepted on the next edge. There is no dead cycle beyond FINISH.
- start while busy is ignored and not queued. bin_in changes while busy have no effect.
- bin_in=0 gives bcd_out=0 and overflow=0 after full latency; there is no early exit.
- Reset asserted mid-conversion aborts immediately. No done pulse is produced, and outputs clear to 0.
- Digit values 10..15 never occur in the scratch register in valid operation. The correction cell still defines them as +3 mod 16.

Optional Feature:
- Macro name: BCD_BLANK_EN.
- When defined:
  - Adds output port blank_n[DIGITS-1:0]. Bit i=1 means digit i is displayed.
  - Updated on the done edge together with bcd_out; reset value 0.
  - Leading-zero digits are blanked (bit=0). Digit 0 is always 1.
  - With overflow set, all bits are 1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bcd_pkg holds:
  - the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2);
  - the constant BCD_CORR_THRESH=4'd5 and BCD_CORR_ADD=4'd3;
  - the function digits_for_width(w), which returns the minimum digit count.
- Sub-module bcd_add3_digit: a 4-bit combinational correction cell (>=5 → +3). It is instantiated DIGITS times through a generate loop.
- Counter width is $clog2(BIN_W+1).

Test Plan:
- BIN_W=16, DIGITS=5, bin_in=16'hFFFF with a start pulse → done after 17 clocks, bcd_out=20'h65535, overflow=0, busy high for 17 cycles.
- bin_in=16'd0, then 16'd9, then 16'd10, issued back-to-back with start in each done cycle → bcd_out=20'h00000, 20'h00009, 20'h00010 in turn. Each done is exactly 1 cycle and the spacing is 17 clocks.
- DIGITS=4, bin_in=16'd12345 → overflow=1, bcd_out=16'h9999. Then bin_in=16'd9999 → overflow=0, bcd_out=16'h9999.
- Start pulsed at cycles 3 and 8 of a conversion of 16'd4321 → both ignored; a single done with bcd_out=20'h04321.
- rst_n dropped at cycle 6 of a conversion → busy, done, bcd_out and overflow are 0 asynchronously, with no done pulse. After release, a new conversion of 16'd777 gives 20'h00777.
- BCD_BLANK_EN defined, bin_in=16'd42 → blank_n=5'b00011. bin_in=0 → blank_n=5'b00001.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, add-3 correction constants and a digit-count helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [3:0] BCD_CORR_THRESH = 4'd5;
  localparam logic [3:0] BCD_CORR_ADD    = 4'd3;

  // Minimum number of decimal digits needed to hold any w-bit unsigned value.
  function automatic int digits_for_width(input int w);
    longint unsigned v;
    int d;
    v = (64'd1 << w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_converter_seq_add3.sv
// Single-digit double-dabble correction cell: digits >= 5 get +3 (mod 16).
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= BCD_CORR_THRESH) ? digit + BCD_CORR_ADD : digit;

endmodule

// File: rtl/bcd_converter_seq.sv
// Iterative binary-to-BCD converter (one bit per clock) with start/busy/done.
// Optional BCD_BLANK_EN adds a leading-zero blanking mask output blank_n.
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_n
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_e                state;
  logic [BIN_W-1:0]      bin_sr;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   corr;
  logic                  sticky_ovf;
  logic [CNT_W-1:0]      cnt;

  function automatic logic [4*DIGITS-1:0] all_nines();
    return {DIGITS{4'h9}};
  endfunction

`ifdef BCD_BLANK_EN
  // Digit i is shown when it or any more-significant digit is non-zero.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] d,
                                                   input logic ovf);
    logic seen;
    logic [DIGITS-1:0] m;
    seen = 1'b0;
    m    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (d[4*i +: 4] != 4'd0) seen = 1'b1;
      m[i] = seen;
    end
    m[0] = 1'b1;
    if (ovf) m = '1;
    return m;
  endfunction
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_corr
    bcd_add3_digit u_digit (
      .digit    (scratch[4*i +: 4]),
      .corrected(corr[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      scratch    <= '0;
      sticky_ovf <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
`ifdef BCD_BLANK_EN
      blank_n    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr     <= bin_in;
            scratch    <= '0;
            sticky_ovf <= 1'b0;
            cnt        <= CNT_W'(BIN_W);
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Bit leaving the top corrected digit means the value no longer fits.
          {scratch, bin_sr} <= {corr[4*DIGITS-2:0], bin_sr, 1'b0};
          if (corr[4*DIGITS-1]) sticky_ovf <= 1'b1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FINISH;
        end
        FINISH: begin
          bcd_out  <= sticky_ovf ? all_nines() : scratch;
          overflow <= sticky_ovf;
`ifdef BCD_BLANK_EN
          blank_n  <= blank_mask(scratch, sticky_ovf);
`endif
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench for bcd_converter_seq (5-digit and 4-digit instances).
module tb_bcd_converter_seq;

  localparam int BIN_W = 16;
  localparam int LAT   = BIN_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, start4 = 1'b0;
  logic [15:0] bin_in = '0, bin_in4 = '0;
  logic        busy, done, overflow;
  logic [19:0] bcd_out;
  logic        busy4, done4, overflow4;
  logic [15:0] bcd_out4;
`ifdef BCD_BLANK_EN
  logic [4:0]  blank_n;
  logic [3:0]  blank_n4;
`endif

  bcd_converter_seq #(.BIN_W(BIN_W), .DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
`ifdef BCD_BLANK_EN
    , .blank_n(blank_n)
`endif
  );

  bcd_converter_seq #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bin_in(bin_in4),
    .busy(busy4), .done(done4), .bcd_out(bcd_out4), .overflow(overflow4)
`ifdef BCD_BLANK_EN
    , .blank_n(blank_n4)
`endif
  );

  typedef struct {
    logic [19:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t sb4[$];
  int checks = 0;
  int errors = 0;

  // Reference by repeated division; saturates to all nines when too large.
  function automatic exp_t model(input int unsigned v, input int digits);
    exp_t e;
    int unsigned t, lim;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    e.bcd = '0;
    e.ovf = (v >= lim);
    t = v;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = e.ovf ? 4'd9 : 4'(t % 10);
      t = t / 10;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] v);
    bin_in = v;
    start  = 1'b1;
    sb.push_back(model(v, 5));
    tick();
    start  = 1'b0;
    bin_in = 16'($urandom);
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bcd_out !== 20'h0) begin errors++; $display("FAIL reset_bcd: got %h want 00000", bcd_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
`ifdef BCD_BLANK_EN
    checks++; if (blank_n !== 5'b0) begin errors++; $display("FAIL reset_blank: got %b want 00000", blank_n); end
`endif
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_max();
    int lat, bc;
    exp_t e;
    launch(16'hFFFF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL max_busy_start: got %b want 1", busy); end
    wait_done(lat, bc);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL max_latency: got %0d want %0d", lat, LAT); end
    checks++; if (bc !== LAT) begin errors++; $display("FAIL max_busy_cycles: got %0d want %0d", bc, LAT); end
    e = sb.pop_front();
    checks++; if (bcd_out !== e.bcd) begin errors++; $display("FAIL max_bcd: got %h want %h", bcd_out, e.bcd); end
    checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL max_ovf: got %b want %b", overflow, e.ovf); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL max_done_pulse: got %b want 0", done); end
    checks++; if (bcd_out !== e.bcd) begin errors++; $display("FAIL max_bcd_hold: got %h want %h", bcd_out, e.bcd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    int lat, bc;
    exp_t e;
    vals[0] = 16'd0; vals[1] = 16'd9; vals[2] = 16'd10;
    launch(vals[0]);
    for (int i = 0; i < 3; i++) begin
      wait_done(lat, bc);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      e = sb.pop_front();
      checks++; if (bcd_out !== e.bcd) begin errors++; $display("FAIL b2b_bcd[%0d]: got %h want %h", i, bcd_out, e.bcd); end
      checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL b2b_ovf[%0d]: got %b want %b", i, overflow, e.ovf); end
      if (i < 2) begin
        launch(vals[i+1]);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d]: busy got %b want 1", i, busy); end
      end else begin
        tick();
      end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width[%0d]: got %b want 0", i, done); end
    end
  endtask

  task automatic test_ignored_start();
    int lat, bc, extra;
    exp_t e;
    launch(16'd4321);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3 || c == 8) begin
        start  = 1'b1;
        bin_in = (c == 3) ? 16'd1234 : 16'd5555;
      end
      tick();
      start = 1'b0;
    end
    wait_done(lat, bc);
    lat = lat + 8;
    checks++; if (lat !== LAT) begin errors++; $display("FAIL ign_latency: got %0d want %0d", lat, LAT); end
    e = sb.pop_front();
    checks++; if (bcd_out !== e.bcd) begin errors++; $display("FAIL ign_bcd: got %h want %h", bcd_out, e.bcd); end
    extra = 0;
    repeat (25) begin
      tick();
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ign_extra_done: got %0d want 0", extra); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_overflow4();
    logic [15:0] vals [3];
    int lat;
    exp_t e;
    vals[0] = 16'd12345; vals[1] = 16'd9999; vals[2] = 16'd10000;
    for (int i = 0; i < 3; i++) begin
      bin_in4 = vals[i];
      start4  = 1'b1;
      sb4.push_back(model(vals[i], 4));
      tick();
      start4  = 1'b0;
      lat = 0;
      while (!done4 && lat < 100) begin
        tick();
        lat++;
      end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL d4_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      e = sb4.pop_front();
      checks++; if (bcd_out4 !== e.bcd[15:0]) begin errors++; $display("FAIL d4_bcd[%0d]: got %h want %h", i, bcd_out4, e.bcd[15:0]); end
      checks++; if (overflow4 !== e.ovf) begin errors++; $display("FAIL d4_ovf[%0d]: got %b want %b", i, overflow4, e.ovf); end
`ifdef BCD_BLANK_EN
      if (e.ovf) begin
        checks++; if (blank_n4 !== 4'b1111) begin errors++; $display("FAIL d4_blank[%0d]: got %b want 1111", i, blank_n4); end
      end
`endif
      tick();
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, seen;
    exp_t e;
    launch(16'd2468);
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (bcd_out !== 20'h0) begin errors++; $display("FAIL abort_bcd: got %h want 00000", bcd_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf: got %b want 0", overflow); end
    seen = 0;
    repeat (3) begin
      tick();
      if (done || busy) seen++;
    end
    #3 rst_n = 1'b1;
    repeat (LAT + 2) begin
      tick();
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", seen); end
    launch(16'd777);
    wait_done(lat, bc);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL abort_latency: got %0d want %0d", lat, LAT); end
    e = sb.pop_front();
    checks++; if (bcd_out !== e.bcd) begin errors++; $display("FAIL abort_bcd_after: got %h want %h", bcd_out, e.bcd); end
    tick();
  endtask

`ifdef BCD_BLANK_EN
  task automatic test_blank();
    int lat, bc;
    exp_t e;
    launch(16'd42);
    wait_done(lat, bc);
    e = sb.pop_front();
    checks++; if (bcd_out !== e.bcd) begin errors++; $display("FAIL blank_bcd42: got %h want %h", bcd_out, e.bcd); end
    checks++; if (blank_n !== 5'b00011) begin errors++; $display("FAIL blank_42: got %b want 00011", blank_n); end
    tick();
    launch(16'd0);
    wait_done(lat, bc);
    e = sb.pop_front();
    checks++; if (blank_n !== 5'b00001) begin errors++; $display("FAIL blank_0: got %b want 00001", blank_n); end
    tick();
    launch(16'd50000);
    wait_done(lat, bc);
    e = sb.pop_front();
    checks++; if (blank_n !== 5'b11111) begin errors++; $display("FAIL blank_50000: got %b want 11111", blank_n); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_ignored_start();
    test_overflow4();
    test_reset_abort();
`ifdef BCD_BLANK_EN
    test_blank();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
